ir_buffer: RTL and testbench

Parametrised instruction register and fetch queue. It sits between the instruction-memory bus and the decode stage of the MIPS core. It accepts in-order read responses from the bus, buffers up to DEPTH instruction words, and presents the head word with its MIPS fields pre-split to decode over a valid/ready handshake. On a taken branch or jump, `flush` empties the queue, and every response still in flight from before the flush is discarded as it arrives.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/instr_fields.sv | 23 ++
 rtl/ir_buffer.sv | 129 ++++++++++++
 tb/tb_ir_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: MIPS instruction-field types shared by the fetch queue and the decoder.
//   opcode_t / funct_t  : 6-bit opcode and function-code types
//   *_MSB / *_LSB       : bit positions of every MIPS field in a 32-bit word
//   instr_fields_t      : packed struct of all fields, including the overlapping
//                         I-type imm16 and J-type target26 views
package mips_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        funct_t      funct;
        logic [15:0] imm16;
        logic [25:0] target26;
    } instr_fields_t;

endpackage

// File: rtl/instr_fields.sv
// instr_fields: purely combinational split of a 32-bit MIPS word into its fields.
//   i_word   : instruction word
//   o_fields : all fields (R, I and J views) as instr_fields_t
module instr_fields
    import mips_pkg::*;
(
    input  logic [31:0]   i_word,
    output instr_fields_t o_fields
);

    always_comb begin
        o_fields          = '0;
        o_fields.opcode   = i_word[OPC_MSB:OPC_LSB];
        o_fields.rs       = i_word[RS_MSB:RS_LSB];
        o_fields.rt       = i_word[RT_MSB:RT_LSB];
        o_fields.rd       = i_word[RD_MSB:RD_LSB];
        o_fields.shamt    = i_word[SHAMT_MSB:SHAMT_LSB];
        o_fields.funct    = i_word[FUNCT_MSB:FUNCT_LSB];
        o_fields.imm16    = i_word[IMM_MSB:IMM_LSB];
        o_fields.target26 = i_word[TGT_MSB:TGT_LSB];
    end

endmodule

// File: rtl/ir_buffer.sv
// ir_buffer: instruction register / fetch queue between the instruction bus and decode.
//   req_issue / can_issue          : fetch-side credit (count + live reads < DEPTH)
//   mem_readdata/mem_readdatavalid : in-order bus read responses
//   flush                          : drop queue and every read in flight before it
//   out_valid/out_ready            : head-of-queue handshake to decode
//   instr_word + field outputs     : head word and its pre-split MIPS fields
//   count                          : entries held
//   overflow_err                   : sticky, push while full or unexpected response
module ir_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_issue,
    output logic             can_issue,
    input  logic [31:0]      mem_readdata,
    input  logic             mem_readdatavalid,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_word,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [25:0]      target26,
    output logic [CNT_W-1:0] count,
    output logic             overflow_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    // Stale reads can pile up across several flushes while new live reads are
    // being issued, so the discard counter gets headroom beyond DEPTH.
    localparam int DISC_W = CNT_W + 2;

    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_outs;
    logic [DISC_W-1:0] r_disc;
    logic              r_ovf;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_rdv_drop;
    logic              w_rdv_live;
    logic              w_rdv_err;
    logic              w_full_err;
    logic [CNT_W:0]    w_occ;
    logic [DISC_W-1:0] w_disc_flush;
    instr_fields_t     w_fields;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign out_valid  = (r_count != '0);
    assign w_pop      = !flush && out_valid && out_ready;

    // Responses retire stale reads first: everything older than a flush
    // arrives before anything issued after it.
    assign w_rdv_drop = mem_readdatavalid && (r_disc != '0);
    assign w_rdv_live = mem_readdatavalid && (r_disc == '0) && (r_outs != '0);
    assign w_rdv_err  = mem_readdatavalid && (r_disc == '0) && (r_outs == '0);

    assign w_push     = !flush && w_rdv_live && (!w_full || w_pop);
    assign w_full_err = !flush && w_rdv_live && w_full && !w_pop;

    // On flush every live read turns stale; a response landing this cycle
    // retires one of them (live or stale alike, its data is dropped).
    assign w_disc_flush = r_disc + DISC_W'(r_outs)
                        - DISC_W'(mem_readdatavalid && !w_rdv_err);

    assign w_occ     = {1'b0, r_count} + {1'b0, r_outs};
    assign can_issue = (w_occ < (CNT_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_outs   <= '0;
            r_disc   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= mem_readdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
                r_outs   <= CNT_W'(req_issue);
                r_disc   <= w_disc_flush;
            end else begin
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                r_outs  <= r_outs + CNT_W'(req_issue) - CNT_W'(w_rdv_live);
                r_disc  <= r_disc - DISC_W'(w_rdv_drop);
            end
            if (w_rdv_err || w_full_err) r_ovf <= 1'b1;
        end
    end

    assign instr_word   = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign overflow_err = r_ovf;

    instr_fields u_fields (
        .i_word   (instr_word),
        .o_fields (w_fields)
    );

    assign opcode   = w_fields.opcode;
    assign rs       = w_fields.rs;
    assign rt       = w_fields.rt;
    assign rd       = w_fields.rd;
    assign shamt    = w_fields.shamt;
    assign funct    = w_fields.funct;
    assign imm16    = w_fields.imm16;
    assign target26 = w_fields.target26;

endmodule

// File: tb/tb_ir_buffer.sv
module tb_ir_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             req_issue;
    logic             can_issue;
    logic [31:0]      mem_readdata;
    logic             mem_readdatavalid;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr_word;
    logic [5:0]       opcode;
    logic [4:0]       rs, rt, rd, shamt;
    logic [5:0]       funct;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [CNT_W-1:0] count;
    logic             overflow_err;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the queue contents, plus one tag per read on the bus
    // (1 = live, 0 = issued before a flush and to be thrown away).
    logic [31:0] m_q[$];
    bit          m_inf[$];
    bit          m_ovf;

    always #5 clk = ~clk;

    ir_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req_issue(req_issue), .can_issue(can_issue),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .instr_word(instr_word), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16), .target26(target26),
        .count(count), .overflow_err(overflow_err)
    );

    function automatic int m_live();
        int n = 0;
        foreach (m_inf[i]) if (m_inf[i]) n++;
        return n;
    endfunction

    function automatic bit m_can_issue();
        return (m_q.size() + m_live()) < DEPTH;
    endfunction

    task automatic model_step();
        bit pop, push, live;
        pop  = (m_q.size() != 0) && out_ready && !flush;
        push = 0;
        if (mem_readdatavalid) begin
            if (m_inf.size() == 0) m_ovf = 1;
            else begin
                live = m_inf[0];
                m_inf.delete(0);
                if (live && !flush) begin
                    if (m_q.size() == DEPTH && !pop) m_ovf = 1;
                    else push = 1;
                end
            end
        end
        if (flush) begin
            foreach (m_inf[i]) m_inf[i] = 0;
            m_q.delete();
        end else begin
            if (pop) m_q.delete(0);
            if (push) m_q.push_back(mem_readdata);
        end
        if (req_issue) m_inf.push_back(1);
    endtask

    task automatic idle_inputs();
        req_issue = 0; mem_readdata = 32'h0; mem_readdatavalid = 0;
        flush = 0; out_ready = 0;
    endtask

    // One clock: advance the model with the inputs about to be sampled,
    // then let the DUT take the edge and sample its outputs 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        m_q.delete(); m_inf.delete(); m_ovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick(); tick();
        n_total++; if (count !== 0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (can_issue !== 1'b1) $display("FAIL reset_can_issue got %b want 1", can_issue); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err); else n_pass++;
        n_total++;
        if ({instr_word, opcode, rs, rt, rd, shamt, funct, imm16, target26} !== '0)
            $display("FAIL reset_fields got word %h op %h want all 0", instr_word, opcode);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            req_issue = 1; tick();
        end
        req_issue = 0;
        n_total++; if (can_issue !== 1'b0) $display("FAIL fill_credit got %b want 0", can_issue); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            mem_readdatavalid = 1; mem_readdata = 32'h8C820004 + 32'(4 * i);
            tick();
            if (i == 0) begin
                n_total++; if (out_valid !== 1'b1) $display("FAIL fill_latency got %b want 1", out_valid); else n_pass++;
            end
        end
        mem_readdatavalid = 0;
        n_total++; if (count !== CNT_W'(DEPTH)) $display("FAIL fill_count got %0d want %0d", count, DEPTH); else n_pass++;
        n_total++; if (can_issue !== 1'b0) $display("FAIL fill_can_issue got %b want 0", can_issue); else n_pass++;
        n_total++;
        if (opcode !== 6'h23 || rs !== 5'd4 || rt !== 5'd2 || imm16 !== 16'h0004)
            $display("FAIL fill_fields got op %h rs %0d rt %0d imm %h want 23 4 2 0004", opcode, rs, rt, imm16);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        req_issue = 1; tick(); req_issue = 0;
        mem_readdatavalid = 1; mem_readdata = 32'hAABB0005; out_ready = 1;
        tick();
        mem_readdatavalid = 0; out_ready = 0;
        n_total++; if (count !== CNT_W'(DEPTH)) $display("FAIL fullpp_count got %0d want %0d", count, DEPTH); else n_pass++;
        n_total++; if (overflow_err !== 1'b0) $display("FAIL fullpp_ovf got %b want 0", overflow_err); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++;
            if (instr_word !== m_q[0]) $display("FAIL fullpp_order[%0d] got %h want %h", i, instr_word, m_q[0]);
            else n_pass++;
            out_ready = 1; tick();
        end
        out_ready = 0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL fullpp_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin req_issue = 1; tick(); end
        req_issue = 0;
        mem_readdatavalid = 1; mem_readdata = 32'h12340000; tick();
        mem_readdatavalid = 0;
        flush = 1; req_issue = 1; tick();
        flush = 0; req_issue = 0;
        n_total++; if (out_valid !== 1'b0 || count !== 0) $display("FAIL flush_clear got v %b cnt %0d want 0 0", out_valid, count); else n_pass++;
        mem_readdatavalid = 1; mem_readdata = 32'h11111111; tick();
        mem_readdata = 32'h22222222; tick();
        n_total++; if (count !== 0) $display("FAIL flush_drop got %0d want 0", count); else n_pass++;
        mem_readdata = 32'h03E00008; tick();
        mem_readdatavalid = 0;
        n_total++; if (count !== 1) $display("FAIL flush_live_count got %0d want 1", count); else n_pass++;
        n_total++;
        if (instr_word !== 32'h03E00008 || funct !== 6'h08 || rs !== 5'd31)
            $display("FAIL flush_live_word got %h f %h rs %0d want 03e00008 08 31", instr_word, funct, rs);
        else n_pass++;
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            req_issue = 1; tick(); req_issue = 0;
            mem_readdatavalid = 1; mem_readdata = w; tick(); mem_readdatavalid = 0;
            n_total++;
            if (out_valid !== 1'b1 || instr_word !== w)
                $display("FAIL wrap[%0d] got v %b %h want 1 %h", i, out_valid, instr_word, w);
            else n_pass++;
            out_ready = 1; tick(); out_ready = 0;
        end
    endtask

    task automatic test_protocol_err();
        mem_readdatavalid = 1; mem_readdata = 32'hDEADBEEF; tick();
        mem_readdatavalid = 0;
        n_total++; if (count !== 0) $display("FAIL proto_count got %0d want 0", count); else n_pass++;
        n_total++; if (overflow_err !== 1'b1) $display("FAIL proto_ovf got %b want 1", overflow_err); else n_pass++;
        tick(); tick();
        n_total++; if (overflow_err !== 1'b1) $display("FAIL proto_sticky got %b want 1", overflow_err); else n_pass++;
        do_reset();
        n_total++; if (overflow_err !== 1'b0) $display("FAIL proto_reset got %b want 0", overflow_err); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_issue = m_can_issue() && ($urandom_range(0, 99) < 60);
            mem_readdatavalid = (m_inf.size() != 0) && ($urandom_range(0, 99) < 55);
            mem_readdata = $urandom;
            flush = ($urandom_range(0, 99) < 6);
            out_ready = ($urandom_range(0, 99) < 50);
            tick();
            n_total++;
            if (count !== CNT_W'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
                can_issue !== m_can_issue() || overflow_err !== m_ovf ||
                (m_q.size() != 0 && (instr_word !== m_q[0] || opcode !== m_q[0][31:26])))
                $display("FAIL rand[%0d] got cnt %0d ci %b ovf %b word %h want cnt %0d ci %b ovf %b word %h",
                         c, count, can_issue, overflow_err, instr_word,
                         m_q.size(), m_can_issue(), m_ovf, (m_q.size() != 0) ? m_q[0] : 32'h0);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_fill();
        test_full_pushpop();
        test_flush();
        test_wrap();
        test_protocol_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
